// File: rtl/mips_pkg.sv
// Shared MIPS constants and types: register-file geometry and named register indices.
package mips_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction
endpackage

// File: rtl/mips_register_file_if.sv
// Register-file port bundle: writeback write port plus decode-stage rs/rt read ports.
interface mips_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/reg32_en.sv
// Single register-file entry: sync active-high clear, loads i_d when i_en is high.
module reg32_en #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/mips_register_file.sv
// 32x32 MIPS register file: one synchronous write port, two combinational read ports,
// $0 hardwired to zero, optional write-first bypass on both read ports.
module mips_register_file #(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int ADDR_W    = mips_pkg::ADDR_W,
  parameter int WR_BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_register_file_if.slave  rf
);
  import mips_pkg::*;

  localparam int   NREGS  = 2 ** ADDR_W;
  localparam logic BYP_EN = (WR_BYPASS != 0);

  logic [DATA_W-1:0] w_regs [NREGS];
  logic [NREGS-1:1]  w_wen;
  logic              w_wr_live;
  logic              w_byp1;
  logic              w_byp2;

  // $0 has no storage behind it.
  assign w_regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      assign w_wen[gi] = rf.we & (rf.waddr == ADDR_W'(gi));

      reg32_en #(.W(DATA_W)) u_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_wen[gi]),
        .i_d   (rf.wdata),
        .o_q   (w_regs[gi])
      );
    end
  endgenerate

  // A write only counts for forwarding if it will actually land at the next edge.
  assign w_wr_live = rf.we & ~reset & (rf.waddr != '0);
  assign w_byp1    = BYP_EN & w_wr_live & (rf.raddr1 == rf.waddr);
  assign w_byp2    = BYP_EN & w_wr_live & (rf.raddr2 == rf.waddr);

  always_comb begin
    rf.rdata1 = '0;
    if (rf.raddr1 != '0) begin
      rf.rdata1 = w_byp1 ? rf.wdata : w_regs[rf.raddr1];
    end
  end

  always_comb begin
    rf.rdata2 = '0;
    if (rf.raddr2 != '0) begin
      rf.rdata2 = w_byp2 ? rf.wdata : w_regs[rf.raddr2];
    end
  end
endmodule
